// File: rtl/log_mem_ctrl_pkg.sv
// Shared constants and types for the FIR output log memory sequencer.
package log_mem_ctrl_pkg;

  localparam int unsigned NB_DATA_DEF = 14;
  localparam int unsigned NB_ADDR_DEF = 10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOG  = 2'd1;
  localparam state_t ST_HOLD = 2'd2;
  localparam state_t ST_READ = 2'd3;

  typedef struct packed {
    logic read_cmd;
    logic log_cmd;
  } cmd_t;

endpackage

// File: rtl/log_mem_ctrl_edge_detect.sv
// Turns toggle-style levels into one-cycle pulses on either edge.
// History is armed on the first clock after reset so a non-zero level is not a command.
module log_mem_ctrl_edge_detect #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] level_i,
  output logic [Width-1:0] pulse_o
);

  logic             armed_q, armed_d;
  logic [Width-1:0] hist_q, hist_d;
  logic [Width-1:0] pulse_q, pulse_d;

  always_comb begin
    armed_d = 1'b1;
    hist_d  = level_i;
    pulse_d = armed_q ? (level_i ^ hist_q) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      armed_q <= 1'b0;
      hist_q  <= '0;
      pulse_q <= '0;
    end else begin
      armed_q <= armed_d;
      hist_q  <= hist_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/log_mem_ctrl.sv
// Capture / read-back sequencer for the FIR output log RAM, driven by front-panel
// toggle levels. The RAM is external with a one-cycle read latency.
module log_mem_ctrl
  import log_mem_ctrl_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_ADDR = NB_ADDR_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_log_btn,
  input  logic               i_read_btn,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_data_valid,
  output logic               o_wr_en,
  output logic [NB_ADDR-1:0] o_wr_addr,
  output logic [NB_DATA-1:0] o_wr_data,
  output logic               o_rd_en,
  output logic [NB_ADDR-1:0] o_rd_addr,
  input  logic [NB_DATA-1:0] i_rd_data,
  input  logic               i_rd_ready,
  output logic [NB_DATA-1:0] o_rd_data,
  output logic               o_rd_valid,
  output logic [NB_ADDR:0]   o_log_count,
  output logic [1:0]         o_state
);

  localparam int unsigned   Depth   = 1 << NB_ADDR;
  localparam logic [NB_ADDR:0] LastCnt = (NB_ADDR + 1)'(Depth - 1);

  logic [1:0] cmd_pulse;
  cmd_t       cmd;

  log_mem_ctrl_edge_detect #(
    .Width (2)
  ) u_edge_detect (
    .clk_i   (i_clock),
    .rst_ni  (i_reset_n),
    .level_i ({i_read_btn, i_log_btn}),
    .pulse_o (cmd_pulse)
  );

  assign cmd = cmd_t'(cmd_pulse);

  state_t             state_q, state_d;
  logic [NB_ADDR:0]   count_q, count_d;
  logic [NB_ADDR:0]   rd_ptr_q, rd_ptr_d;
  logic               wr_en_q, wr_en_d;
  logic [NB_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [NB_DATA-1:0] wr_data_q, wr_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [NB_DATA-1:0] rd_last_q, rd_last_d;
  logic [NB_ADDR-1:0] rd_addr_last_q, rd_addr_last_d;
  logic               rd_issue;

  // Any pending command aborts the read, so no new read is issued alongside it.
  assign rd_issue = (state_q == ST_READ) && i_rd_ready && (rd_ptr_q < count_q) &&
                    !cmd.log_cmd && !cmd.read_cmd;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    rd_ptr_d       = rd_ptr_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    rd_valid_d     = rd_issue;
    rd_last_d      = rd_valid_q ? i_rd_data : rd_last_q;
    rd_addr_last_d = rd_addr_last_q;

    if (rd_issue) begin
      rd_ptr_d       = rd_ptr_q + 1'b1;
      rd_addr_last_d = rd_ptr_q[NB_ADDR-1:0];
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd.log_cmd) begin
          state_d = ST_LOG;
          count_d = '0;
        end
      end
      ST_LOG: begin
        // The write address always equals the number of words captured so far.
        if (i_data_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = count_q[NB_ADDR-1:0];
          wr_data_d = i_data;
          count_d   = count_q + 1'b1;
          if (count_q == LastCnt) state_d = ST_HOLD;
        end
        if (cmd.log_cmd) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cmd.log_cmd) begin
          state_d = ST_LOG;
          count_d = '0;
        end else if (cmd.read_cmd) begin
          if (count_q != '0) begin
            state_d  = ST_READ;
            rd_ptr_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_READ: begin
        if (cmd.log_cmd) begin
          state_d = ST_LOG;
          count_d = '0;
        end else if (cmd.read_cmd) begin
          state_d = ST_HOLD;
        end else if (rd_ptr_q == count_q) begin
          // Last read issued on the previous edge; its valid is out this cycle.
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      rd_ptr_q       <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      rd_last_q      <= '0;
      rd_addr_last_q <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      rd_valid_q     <= rd_valid_d;
      rd_last_q      <= rd_last_d;
      rd_addr_last_q <= rd_addr_last_d;
    end
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_rd_en     = rd_issue;
  assign o_rd_addr   = rd_issue ? rd_ptr_q[NB_ADDR-1:0] : rd_addr_last_q;
  assign o_rd_data   = rd_valid_q ? i_rd_data : rd_last_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_log_count = count_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_log_mem_ctrl.sv
// Bench for log_mem_ctrl with a small RAM model and a capture/read-back scoreboard.
module tb_log_mem_ctrl;

  localparam int unsigned NbData = 14;
  localparam int unsigned NbAddr = 3;
  localparam int unsigned Depth  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              log_btn = 1'b0;
  logic              read_btn = 1'b0;
  logic [NbData-1:0] din = '0;
  logic              dval = 1'b0;
  logic              rd_ready = 1'b0;
  logic              wr_en;
  logic [NbAddr-1:0] wr_addr;
  logic [NbData-1:0] wr_data;
  logic              rd_en;
  logic [NbAddr-1:0] rd_addr;
  logic [NbData-1:0] ram_dout;
  logic [NbData-1:0] rd_dout;
  logic              rd_valid;
  logic [NbAddr:0]   cnt;
  logic [1:0]        state;

  always #5 clk = ~clk;

  log_mem_ctrl #(
    .NB_DATA (NbData),
    .NB_ADDR (NbAddr)
  ) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_log_btn    (log_btn),
    .i_read_btn   (read_btn),
    .i_data       (din),
    .i_data_valid (dval),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_rd_en      (rd_en),
    .o_rd_addr    (rd_addr),
    .i_rd_data    (ram_dout),
    .i_rd_ready   (rd_ready),
    .o_rd_data    (rd_dout),
    .o_rd_valid   (rd_valid),
    .o_log_count  (cnt),
    .o_state      (state)
  );

  // External RAM: registered write, one-cycle read latency.
  logic [NbData-1:0] mem [Depth];
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) ram_dout <= mem[rd_addr];
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_obs[$];
  int rd_obs[$];
  int exp_log[$];
  int rd_en_cnt = 0;
  int first_v = -1;
  int last_v = -1;
  bit prev_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: collects writes and read-backs, checks read strobe/valid timing.
  always begin
    @(negedge clk);
    if (!rst_n) begin
      prev_en = 1'b0;
    end else begin
      if (wr_en) wr_obs.push_back((int'(wr_addr) << 16) | int'(wr_data));
      if (rd_valid) begin
        rd_obs.push_back(int'(rd_dout));
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (rd_en) begin
        rd_en_cnt++;
        chk("rd_en_needs_ready", int'(rd_ready), 1);
      end
      if (rd_en || prev_en || rd_valid) chk("rd_valid_lag", int'(rd_valid), int'(prev_en));
      prev_en = rd_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Capture n samples; the log holds the first Depth of them.
  task automatic do_log(input int n, input bit stop, input bit rnd, input int base);
    logic [NbData-1:0] d;
    exp_log.delete();
    wr_obs.delete();
    log_btn = ~log_btn;
    ticks(3);
    chk("log_entered", int'(state), 1);
    chk("log_count_cleared", int'(cnt), 0);
    for (int i = 0; i < n; i++) begin
      if (rnd && ($urandom_range(0, 1) == 1)) begin
        dval = 1'b0;
        tick();
      end
      d = rnd ? NbData'($urandom) : NbData'(base + i + 1);
      din = d;
      dval = 1'b1;
      tick();
      if (exp_log.size() < Depth) exp_log.push_back(int'(d));
    end
    dval = 1'b0;
    if (stop) begin
      log_btn = ~log_btn;
      ticks(3);
    end
    ticks(2);
    chk("wr_count", wr_obs.size(), exp_log.size());
    for (int i = 0; i < wr_obs.size() && i < exp_log.size(); i++) begin
      chk("wr_addr", wr_obs[i] >> 16, i);
      chk("wr_data", wr_obs[i] & 32'hffff, exp_log[i]);
    end
    chk("hold_count", int'(cnt), exp_log.size());
    chk("hold_state", int'(state), 2);
  endtask

  // mode 0: ready always, 1: alternating, 2: random.
  task automatic do_read(input int mode);
    int en0;
    bit seen;
    bit done;
    rd_obs.delete();
    first_v = -1;
    last_v = -1;
    en0 = rd_en_cnt;
    rd_ready = 1'b1;
    read_btn = ~read_btn;
    if (exp_log.size() == 0) begin
      ticks(3);
      chk("empty_read_to_idle", int'(state), 0);
      chk("empty_read_no_rd_en", rd_en_cnt - en0, 0);
      return;
    end
    seen = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      tick();
      if (state == 2'd3) seen = 1'b1;
      else if (seen && state == 2'd2) done = 1'b1;
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ~rd_ready;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
    end
    rd_ready = 1'b0;
    chk("read_finished", int'(done), 1);
    ticks(2);
    chk("rd_count", rd_obs.size(), exp_log.size());
    for (int i = 0; i < rd_obs.size() && i < exp_log.size(); i++)
      chk("rd_data", rd_obs[i], exp_log[i]);
    chk("rd_en_total", rd_en_cnt - en0, exp_log.size());
    chk("after_read_state", int'(state), 2);
    chk("after_read_count", int'(cnt), exp_log.size());
    if (mode == 0) chk("rd_back_to_back", last_v - first_v, exp_log.size() - 1);
  endtask

  typedef struct {
    int n;
    bit stop;
    int mode;
    int exp_cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int en0;
    int n;
    vecs[0] = '{9, 1'b0, 0, 8};
    vecs[1] = '{3, 1'b1, 0, 3};
    vecs[2] = '{8, 1'b0, 1, 8};
    vecs[3] = '{5, 1'b1, 2, 5};
    vecs[4] = '{1, 1'b1, 1, 1};
    vecs[5] = '{12, 1'b0, 2, 8};

    #12;
    chk("rst_state", int'(state), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_count", int'(cnt), 0);
    chk("rst_rd_data", int'(rd_dout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(3);

    // READ command with nothing logged is ignored.
    read_btn = ~read_btn;
    ticks(5);
    chk("idle_read_ignored", int'(state), 0);
    chk("idle_no_rd_en", rd_en_cnt, 0);

    for (int i = 0; i < 6; i++) begin
      do_log(vecs[i].n, vecs[i].stop, 1'b0, i * 16);
      chk("tbl_count", int'(cnt), vecs[i].exp_cnt);
      do_read(vecs[i].mode);
    end

    // Both buttons at once in HOLD: LOG wins, nothing read.
    en0 = rd_en_cnt;
    log_btn = ~log_btn;
    read_btn = ~read_btn;
    ticks(3);
    chk("both_cmd_state", int'(state), 1);
    chk("both_cmd_count", int'(cnt), 0);
    ticks(3);
    chk("both_cmd_no_read", rd_en_cnt - en0, 0);
    log_btn = ~log_btn;
    ticks(3);
    chk("empty_hold_state", int'(state), 2);
    read_btn = ~read_btn;
    ticks(3);
    chk("empty_hold_read_idle", int'(state), 0);

    for (int e = 0; e < 12; e++) begin
      n = $urandom_range(0, 11);
      do_log(n, n < 8, 1'b1, 0);
      do_read(2);
      if (n > 0 && $urandom_range(0, 1) == 1) do_read(0);
    end

    // Asynchronous reset in the middle of a capture.
    log_btn = ~log_btn;
    ticks(3);
    din = 14'h123;
    dval = 1'b1;
    ticks(3);
    chk("pre_rst_wr_en", int'(wr_en), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_wr_en", int'(wr_en), 0);
    chk("async_rst_count", int'(cnt), 0);
    dval = 1'b0;
    ticks(2);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(4);
    chk("no_false_cmd", int'(state), 0);
    log_btn = ~log_btn;
    ticks(3);
    chk("log_after_rst", int'(state), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
